brk_ctrl: RTL and testbench
===========================

BRK_CTRL -- requirements
Module: brk_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 32'h0000_0100, base address of the trap vector table.
REQ-002 Parameter DRAIN_CYCLES, default 3, number of pipeline drain cycles before vectoring; legal range 1..15.
REQ-003 clk  in  1  rising-edge clock shared with the fetch stage.
REQ-004 rst  in  1  one clock; reset is asynchronous and active-high.
REQ-005 irq_req  in  1  level external interrupt request.
REQ-006 irq_cause  in  3  external interrupt index, sampled with irq_req.
REQ-007 sw_brk  in  1  break instruction decoded in ID, one-cycle pulse.
REQ-008 eret  in  1  return-from-trap instruction decoded in ID, one-cycle pulse.
REQ-009 id_pc  in  32  PC of the instruction currently in ID.
REQ-010 hazard_stall  in  1  load-use stall request from the hazard unit.
REQ-011 PCWrite  out  1  PC update enable to fetch.
REQ-012 brk  out  1  forced PC load strobe to fetch.
REQ-013 brk_vec  out  32  address loaded into PC when brk=1.
REQ-014 flush  out  1  IF/ID flush pulse.
REQ-015 epc  out  32  saved return address.
REQ-016 cause  out  4  saved trap cause.
REQ-017 in_service  out  1  high while a trap handler runs.

Function
REQ-018 States SHALL be RUN, DRAIN, VECTOR, SERVICE, RETURN, held in a state register.
REQ-019 RUN: PCWrite = ~hazard_stall; on sw_brk or irq_req sampled high, SHALL capture epc<=id_pc, cause, load drain counter with DRAIN_CYCLES-1, go to DRAIN.
REQ-020 Cause encoding: sw_brk -> 4'h0; irq -> {1'b1, irq_cause}; sw_brk wins when both high in the same cycle.
REQ-021 DRAIN: PCWrite=0; flush=1 in the first DRAIN cycle only; counter decrements each cycle; at count 0 go to VECTOR; DRAIN lasts exactly DRAIN_CYCLES cycles.
REQ-022 VECTOR: brk=1 for exactly one cycle, brk_vec = VEC_BASE + {cause, 4'b0000} (32-bit add, wrap ignored); next state SERVICE.
REQ-023 SERVICE: in_service=1, PCWrite = ~hazard_stall; irq_req and sw_brk SHALL be ignored (no nesting); eret -> RETURN.
REQ-024 RETURN: brk=1 for one cycle, brk_vec = epc, in_service cleared at end of cycle; next state RUN.
REQ-025 eret in RUN, DRAIN or VECTOR SHALL be ignored.
REQ-026 brk, flush, in_service SHALL be decoded from the state register only (glitch-free w.r.t. inputs); brk_vec SHALL be registered.
REQ-027 brk and PCWrite SHALL never be high in the same cycle.
REQ-028 hazard_stall SHALL have no effect in DRAIN, VECTOR, RETURN.
REQ-029 epc and cause SHALL hold their values from capture until the next trap capture.
REQ-030 A trap request already captured SHALL complete even if irq_req deasserts during DRAIN.

Reset
REQ-031 rst high SHALL immediately force state RUN, PCWrite=0, brk=0, brk_vec=0, flush=0, epc=0, cause=0, in_service=0, drain counter=0.
REQ-032 After rst deasserts, first rising edge SHALL evaluate RUN normally; PCWrite = ~hazard_stall.
REQ-033 rst asserted mid-DRAIN, VECTOR or SERVICE SHALL abandon the trap with no brk pulse.

Verification
REQ-034 id_pc=32'h40, sw_brk pulse at edge 0 -> flush=1 cycle 1, PCWrite=0 cycles 1-3, brk=1 cycle 4 with brk_vec=32'h100, epc=32'h40, cause=0.
REQ-035 irq_req=1, irq_cause=3'd2, id_pc=32'h80 -> cause=4'hA, brk_vec=32'h1A0 in VECTOR cycle.
REQ-036 In SERVICE, eret pulse -> next cycle brk=1, brk_vec=32'h40, following cycle in_service=0, PCWrite=1.
REQ-037 sw_brk and irq_req same cycle -> cause=0; irq_req held through SERVICE -> no second brk until after RETURN.
REQ-038 hazard_stall=1 in RUN -> PCWrite=0; rst pulse during DRAIN -> all outputs zero, no brk pulse afterwards.

Source files
------------

// File: rtl/brk_ctrl.sv
// Trap/break controller: captures break or interrupt, drains the pipeline,
// vectors fetch to the handler and returns on eret.
module brk_ctrl #(
    parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq_req,
    input  logic [2:0]  irq_cause,
    input  logic        sw_brk,
    input  logic        eret,
    input  logic [31:0] id_pc,
    input  logic        hazard_stall,
    output logic        PCWrite,
    output logic        brk,
    output logic [31:0] brk_vec,
    output logic        flush,
    output logic [31:0] epc,
    output logic [3:0]  cause,
    output logic        in_service
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        DRAIN   = 3'd1,
        VECTOR  = 3'd2,
        SERVICE = 3'd3,
        RETURN  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] brk_vec_q, brk_vec_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
            brk_vec_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            brk_vec_q <= brk_vec_d;
        end
    end

    // brk_vec is loaded on entry to VECTOR/RETURN so it is stable while brk is high
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        brk_vec_d = brk_vec_q;
        case (state_q)
            RUN: begin
                if (sw_brk || irq_req) begin
                    epc_d   = id_pc;
                    cause_d = sw_brk ? 4'h0 : {1'b1, irq_cause};
                    cnt_d   = DRAIN_LOAD;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d   = VECTOR;
                    brk_vec_d = VEC_BASE + 32'({cause_q, 4'b0000});
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            VECTOR: state_d = SERVICE;
            SERVICE: begin
                if (eret) begin
                    state_d   = RETURN;
                    brk_vec_d = epc_q;
                end
            end
            RETURN:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign brk        = (state_q == VECTOR) || (state_q == RETURN);
    assign flush      = (state_q == DRAIN) && (cnt_q == DRAIN_LOAD);
    assign in_service = (state_q == SERVICE) || (state_q == RETURN);
    // rst gating keeps PCWrite low while reset is held even though state reads RUN
    assign PCWrite    = ((state_q == RUN) || (state_q == SERVICE)) && !hazard_stall && !rst;
    assign brk_vec    = brk_vec_q;
    assign epc        = epc_q;
    assign cause      = cause_q;

endmodule

// File: tb/tb_brk_ctrl.sv
// Directed bench for brk_ctrl: break, interrupt, priority, no-nesting and reset abort.
module tb_brk_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq_req;
    logic [2:0]  irq_cause;
    logic        sw_brk;
    logic        eret;
    logic [31:0] id_pc;
    logic        hazard_stall;
    logic        PCWrite;
    logic        brk;
    logic [31:0] brk_vec;
    logic        flush;
    logic [31:0] epc;
    logic [3:0]  cause;
    logic        in_service;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    brk_ctrl #(.VEC_BASE(32'h0000_0100), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .irq_req(irq_req), .irq_cause(irq_cause),
        .sw_brk(sw_brk), .eret(eret), .id_pc(id_pc), .hazard_stall(hazard_stall),
        .PCWrite(PCWrite), .brk(brk), .brk_vec(brk_vec), .flush(flush),
        .epc(epc), .cause(cause), .in_service(in_service)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".PCWrite"}, 32'(PCWrite), 0);
        check({tag, ".brk"}, 32'(brk), 0);
        check({tag, ".brk_vec"}, brk_vec, 0);
        check({tag, ".flush"}, 32'(flush), 0);
        check({tag, ".epc"}, epc, 0);
        check({tag, ".cause"}, 32'(cause), 0);
        check({tag, ".in_service"}, 32'(in_service), 0);
    endtask

    initial begin
        rst = 1'b1; irq_req = 1'b0; irq_cause = '0; sw_brk = 1'b0;
        eret = 1'b0; id_pc = '0; hazard_stall = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge clk); #3;
        rst = 1'b0;
        #3;
        check("run.pcwrite", 32'(PCWrite), 1);
        hazard_stall = 1'b1; #1;
        check("run.stall", 32'(PCWrite), 0);
        hazard_stall = 1'b0;

        // software break from RUN
        tick();
        id_pc = 32'h40; sw_brk = 1'b1;
        tick();
        sw_brk = 1'b0; id_pc = 32'h44;
        check("brk.c1.flush", 32'(flush), 1);
        check("brk.c1.pcwrite", 32'(PCWrite), 0);
        check("brk.c1.brk", 32'(brk), 0);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("brk.c2.flush", 32'(flush), 0);
        check("brk.c2.pcwrite", 32'(PCWrite), 0);
        tick();
        check("brk.c3.pcwrite", 32'(PCWrite), 0);
        check("brk.c3.brk", 32'(brk), 0);
        tick();
        check("brk.c4.brk", 32'(brk), 1);
        check("brk.c4.vec", brk_vec, 32'h100);
        check("brk.c4.pcwrite", 32'(PCWrite), 0);
        check("brk.epc", epc, 32'h40);
        check("brk.cause", 32'(cause), 0);
        tick();
        check("svc.in_service", 32'(in_service), 1);
        check("svc.brk", 32'(brk), 0);
        check("svc.pcwrite", 32'(PCWrite), 1);
        hazard_stall = 1'b1; #1;
        check("svc.stall", 32'(PCWrite), 0);
        hazard_stall = 1'b0;
        sw_brk = 1'b1; irq_req = 1'b1; irq_cause = 3'd7;
        tick();
        sw_brk = 1'b0; irq_req = 1'b0;
        check("svc.nonest.brk", 32'(brk), 0);
        check("svc.nonest.insvc", 32'(in_service), 1);
        check("svc.nonest.cause", 32'(cause), 0);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("ret.brk", 32'(brk), 1);
        check("ret.vec", brk_vec, 32'h40);
        check("ret.pcwrite", 32'(PCWrite), 0);
        check("ret.insvc", 32'(in_service), 1);
        tick();
        check("ret.after.insvc", 32'(in_service), 0);
        check("ret.after.pcwrite", 32'(PCWrite), 1);
        check("ret.after.brk", 32'(brk), 0);

        // interrupt, deasserted during drain, stall ignored in drain
        irq_req = 1'b1; irq_cause = 3'd2; id_pc = 32'h80;
        tick();
        irq_req = 1'b0; hazard_stall = 1'b1;
        check("irq.flush", 32'(flush), 1);
        check("irq.drain.pcwrite", 32'(PCWrite), 0);
        tick(); tick(); tick();
        check("irq.brk", 32'(brk), 1);
        check("irq.vec", brk_vec, 32'h1A0);
        check("irq.cause", 32'(cause), 32'hA);
        check("irq.epc", epc, 32'h80);
        check("irq.vec.pcwrite", 32'(PCWrite), 0);
        hazard_stall = 1'b0;
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("irq.ret.vec", brk_vec, 32'h80);
        check("irq.ret.brk", 32'(brk), 1);
        tick();

        // simultaneous break and interrupt; interrupt held through service
        sw_brk = 1'b1; irq_req = 1'b1; irq_cause = 3'd5; id_pc = 32'h200;
        tick();
        sw_brk = 1'b0;
        tick(); tick(); tick();
        check("prio.cause", 32'(cause), 0);
        check("prio.vec", brk_vec, 32'h100);
        check("prio.brk", 32'(brk), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("prio.svc.brk", 32'(brk), 0);
            check("prio.svc.insvc", 32'(in_service), 1);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("prio.ret.brk", 32'(brk), 1);
        check("prio.ret.vec", brk_vec, 32'h200);
        id_pc = 32'h300;
        tick();
        check("prio.run.pcwrite", 32'(PCWrite), 1);
        check("prio.run.insvc", 32'(in_service), 0);
        tick();
        irq_req = 1'b0;
        check("retrap.flush", 32'(flush), 1);
        check("retrap.cause", 32'(cause), 32'hD);
        check("retrap.epc", epc, 32'h300);

        // asynchronous reset mid-drain abandons the trap
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rstdrain");
        #4;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rstdrain.nobrk", 32'(brk), 0);
            check("rstdrain.pcwrite", 32'(PCWrite), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
